// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, ALU codes,
// sequencer state encoding and the control-output bundle.
package cpu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned ALU_W = 2;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'h8;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

  localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_W-1:0] ALU_OR  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0,
    S_FETCH_MEM  = 4'd1,
    S_FETCH_IR   = 4'd2,
    S_DECODE     = 4'd3,
    S_OPND_ADDR  = 4'd4,
    S_OPND_MEM   = 4'd5,
    S_EXEC       = 4'd6,
    S_STORE_MEM  = 4'd7,
    S_HALT       = 4'd8,
    S_STEP_WAIT  = 4'd9
  } state_e;

  typedef struct packed {
    logic             pc_en;
    logic             ir_en;
    logic             mar_en;
    logic             mdr_en;
    logic             acc_en;
    logic             mar_sel;
    logic             pc_sel;
    logic             acc_sel;
    logic [ALU_W-1:0] alu_op;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic             illegal_op;
  } ctrl_out_t;

  // ALU opcodes are laid out contiguously starting at ADD
  function automatic logic [ALU_W-1:0] alu_op_of(input logic [OPC_W-1:0] op);
    return ALU_W'(op - OP_ADD);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath/memory (slave).
interface cpu_ctrl_fsm_if;
  import cpu_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             acc_zero;
  logic             mem_ready;
  logic             step;

  logic             pc_en;
  logic             ir_en;
  logic             mar_en;
  logic             mdr_en;
  logic             acc_en;
  logic             mar_sel;
  logic             pc_sel;
  logic             acc_sel;
  logic [ALU_W-1:0] alu_op;
  logic             mem_req;
  logic             mem_we;
  logic             halted;
  logic             illegal_op;

  modport master (
    input  opcode, acc_zero, mem_ready, step,
    output pc_en, ir_en, mar_en, mdr_en, acc_en, mar_sel, pc_sel, acc_sel,
           alu_op, mem_req, mem_we, halted, illegal_op
  );

  modport slave (
    output opcode, acc_zero, mem_ready, step,
    input  pc_en, ir_en, mar_en, mdr_en, acc_en, mar_sel, pc_sel, acc_sel,
           alu_op, mem_req, mem_we, halted, illegal_op
  );

endinterface

// File: rtl/cpu_op_decode.sv
// Combinational opcode classifier for the control sequencer.
module cpu_op_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic             is_mem_o,
  output logic             is_store_o,
  output logic             is_alu_o,
  output logic             is_jump_o,
  output logic             is_halt_o,
  output logic             is_illegal_o
);

  always_comb begin
    is_mem_o     = 1'b0;
    is_store_o   = 1'b0;
    is_alu_o     = 1'b0;
    is_jump_o    = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_NOP:   ;
      OP_LOAD:  is_mem_o = 1'b1;
      OP_STORE: begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu_o  = 1'b1;
      OP_JMP, OP_JZ:                 is_jump_o = 1'b1;
      OP_HALT:                       is_halt_o = 1'b1;
      default:                       is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit accumulator CPU.
// Optional single-step mode: define CPU_CTRL_SINGLE_STEP_EN.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned RESET_PC_SEL = 0,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst,
  cpu_ctrl_fsm_if.master bus
);

`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam state_e DONE_STATE = S_STEP_WAIT;
`else
  localparam state_e DONE_STATE = S_FETCH_ADDR;
`endif

  state_e    state_q, state_d;
  logic      illegal_q, illegal_d;
  ctrl_out_t out_c;

  logic is_mem, is_store, is_alu, is_jump, is_halt, is_illegal;

  cpu_op_decode u_op_decode (
    .opcode_i     (bus.opcode),
    .is_mem_o     (is_mem),
    .is_store_o   (is_store),
    .is_alu_o     (is_alu),
    .is_jump_o    (is_jump),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  // Next state and Moore output decode; only mdr_en looks at mem_ready
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    out_c     = '0;
    case (state_q)
      S_FETCH_ADDR: begin
        out_c.mar_en = 1'b1;
        state_d      = S_FETCH_MEM;
      end
      S_FETCH_MEM: begin
        out_c.mem_req = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        out_c.ir_en = 1'b1;
        out_c.pc_en = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        if (is_jump) begin
          out_c.pc_sel = 1'b1;
          out_c.pc_en  = (bus.opcode == OP_JMP) | bus.acc_zero;
        end
        if (is_illegal) illegal_d = 1'b1;
        if (is_halt)                 state_d = S_HALT;
        else if (is_mem || is_alu)   state_d = S_OPND_ADDR;
        else                         state_d = DONE_STATE;
      end
      S_OPND_ADDR: begin
        out_c.mar_en  = 1'b1;
        out_c.mar_sel = 1'b1;
        state_d       = is_store ? S_STORE_MEM : S_OPND_MEM;
      end
      S_OPND_MEM: begin
        out_c.mem_req = 1'b1;
        if (bus.mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        out_c.acc_en = 1'b1;
        if (is_alu) out_c.alu_op  = alu_op_of(bus.opcode);
        else        out_c.acc_sel = 1'b1;
        state_d = DONE_STATE;
      end
      S_STORE_MEM: begin
        out_c.mem_req = 1'b1;
        out_c.mem_we  = 1'b1;
        if (bus.mem_ready) state_d = DONE_STATE;
      end
      S_HALT: out_c.halted = 1'b1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        out_c.halted = 1'b1;
        if (bus.step) state_d = S_FETCH_ADDR;
      end
`endif
      default: state_d = S_FETCH_ADDR;
    endcase
    out_c.mdr_en     = out_c.mem_req & ~out_c.mem_we & bus.mem_ready;
    out_c.illegal_op = illegal_q;
    // Outputs are held quiet for as long as reset is asserted
    if (rst) out_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH_ADDR;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.pc_en      = out_c.pc_en;
  assign bus.ir_en      = out_c.ir_en;
  assign bus.mar_en     = out_c.mar_en;
  assign bus.mdr_en     = out_c.mdr_en;
  assign bus.acc_en     = out_c.acc_en;
  assign bus.mar_sel    = out_c.mar_sel;
  assign bus.pc_sel     = out_c.pc_sel;
  assign bus.acc_sel    = out_c.acc_sel;
  assign bus.alu_op     = out_c.alu_op;
  assign bus.mem_req    = out_c.mem_req;
  assign bus.mem_we     = out_c.mem_we;
  assign bus.halted     = out_c.halted;
  assign bus.illegal_op = out_c.illegal_op;

  // Reserved parameters (and step when single-step is not built) have no logic
  logic unused_c;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  assign unused_c = ^{1'(RESET_PC_SEL), 1'(MEM_WAIT_MAX)};
`else
  assign unused_c = ^{1'(RESET_PC_SEL), 1'(MEM_WAIT_MAX), bus.step};
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: per-cycle output trace scoreboard,
// table-driven instruction latencies and hand-written reset/halt sequences.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam int STEP_EXTRA = 2;
`else
  localparam int STEP_EXTRA = 0;
`endif

  typedef struct {
    logic [3:0] op;
    logic       az;
    int         nw;
    int         lat;
  } vec_t;

  localparam int NVEC = 13;

  logic clk;
  logic rst;
  logic stp;
  logic ill;
  int   errors;
  int   checks;

  ctrl_out_t sb[$];
  int        lat_q[$];
  int        pc_cnt, ir_cnt, ncyc, last_fa;
  logic      have_fa;
  vec_t      tbl[NVEC];

  cpu_ctrl_fsm_if bus ();

  cpu_ctrl_fsm #(
    .RESET_PC_SEL (0),
    .MEM_WAIT_MAX (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Observes the DUT: fetch-to-fetch intervals and enable pulse counts
  always @(negedge clk) begin
    if (rst) begin
      ncyc = 0; have_fa = 1'b0; last_fa = 0;
      pc_cnt = 0; ir_cnt = 0;
      lat_q.delete();
    end else begin
      if (bus.mar_en && !bus.mar_sel) begin
        if (have_fa) lat_q.push_back(ncyc - last_fa);
        last_fa = ncyc;
        have_fa = 1'b1;
      end
      if (bus.pc_en) pc_cnt++;
      if (bus.ir_en) ir_cnt++;
      ncyc++;
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic ctrl_out_t base();
    ctrl_out_t e;
    e = '0;
    e.illegal_op = ill;
    return e;
  endfunction

  // One clock: drive inputs, queue expectation, compare mid-cycle, advance
  task automatic cyc(input logic rdy, input ctrl_out_t e);
    ctrl_out_t act, exp_v;
    bus.mem_ready = rdy;
    bus.step      = stp;
    stp           = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    exp_v = sb.pop_front();
    act = {bus.pc_en, bus.ir_en, bus.mar_en, bus.mdr_en, bus.acc_en, bus.mar_sel,
           bus.pc_sel, bus.acc_sel, bus.alu_op, bus.mem_req, bus.mem_we,
           bus.halted, bus.illegal_op};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL trace t=%0t op=%h: got=%b want=%b (pc ir mar mdr acc msel psel asel alu2 req we halt ill)",
               $time, bus.opcode, act, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mem_acc(input int nw, input logic we, input logic last);
    ctrl_out_t e;
    for (int k = 0; k <= nw; k++) begin
      e = base();
      e.mem_req = 1'b1;
      e.mem_we  = we;
      e.mdr_en  = (k == nw) && !we;
      if (last && k == nw) stp = 1'b1;
      cyc(k == nw, e);
    end
  endtask

  task automatic step_wait();
`ifdef CPU_CTRL_SINGLE_STEP_EN
    ctrl_out_t e;
    e = base();
    e.halted = 1'b1;
    cyc(1'($urandom), e);
    stp = 1'b1;
    cyc(1'($urandom), e);
`endif
  endtask

  task automatic run_instr(input logic [3:0] op, input logic az, input int nw);
    ctrl_out_t e;
    bus.opcode   = op;
    bus.acc_zero = az;
    e = base(); e.mar_en = 1'b1;
    cyc(1'($urandom), e);
    mem_acc(nw, 1'b0, 1'b0);
    e = base(); e.ir_en = 1'b1; e.pc_en = 1'b1;
    cyc(1'($urandom), e);
    e = base();
    if (op == OP_JMP) begin e.pc_en = 1'b1; e.pc_sel = 1'b1; end
    if (op == OP_JZ)  begin e.pc_en = az;   e.pc_sel = 1'b1; end
    if (op == OP_HALT) begin
      cyc(1'($urandom), e);
      for (int k = 0; k < 4; k++) begin
        e = base(); e.halted = 1'b1;
        stp = 1'($urandom);
        cyc(1'($urandom), e);
      end
    end else if (op inside {OP_NOP, OP_JMP, OP_JZ} || op inside {[4'h9:4'hE]}) begin
      stp = 1'b1;
      cyc(1'($urandom), e);
      if (op inside {[4'h9:4'hE]}) ill = 1'b1;
      step_wait();
    end else begin
      cyc(1'($urandom), e);
      e = base(); e.mar_en = 1'b1; e.mar_sel = 1'b1;
      cyc(1'($urandom), e);
      if (op == OP_STORE) begin
        mem_acc(nw, 1'b1, 1'b1);
      end else begin
        mem_acc(nw, 1'b0, 1'b0);
        e = base(); e.acc_en = 1'b1;
        case (op)
          OP_LOAD: e.acc_sel = 1'b1;
          OP_ADD:  e.alu_op  = ALU_ADD;
          OP_SUB:  e.alu_op  = ALU_SUB;
          OP_AND:  e.alu_op  = ALU_AND;
          default: e.alu_op  = ALU_OR;
        endcase
        stp = 1'b1;
        cyc(1'($urandom), e);
      end
      step_wait();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'($urandom), '0);
    cyc(1'($urandom), '0);
    rst = 1'b0;
    ill = 1'b0;
  endtask

  initial begin
    ctrl_out_t e;
    errors = 0; checks = 0;
    rst = 1'b1; stp = 1'b0; ill = 1'b0;
    bus.opcode = '0; bus.acc_zero = 1'b0; bus.mem_ready = 1'b0; bus.step = 1'b0;

    tbl[0]  = '{OP_LOAD,  1'b0, 3, 13};
    tbl[1]  = '{OP_SUB,   1'b0, 0, 7};
    tbl[2]  = '{OP_STORE, 1'b0, 1, 8};
    tbl[3]  = '{OP_ADD,   1'b1, 0, 7};
    tbl[4]  = '{OP_AND,   1'b0, 2, 11};
    tbl[5]  = '{OP_OR,    1'b0, 0, 7};
    tbl[6]  = '{OP_JZ,    1'b0, 0, 4};
    tbl[7]  = '{OP_JZ,    1'b1, 1, 5};
    tbl[8]  = '{OP_JMP,   1'b0, 0, 4};
    tbl[9]  = '{4'hA,     1'b0, 0, 4};
    tbl[10] = '{OP_NOP,   1'b0, 2, 6};
    tbl[11] = '{OP_LOAD,  1'b0, 0, 7};
    tbl[12] = '{4'hE,     1'b1, 0, 4};

    @(posedge clk);
    #1;
    do_reset();

    // NOP then HALT with zero-wait memory
    run_instr(OP_NOP, 1'b0, 0);
    run_instr(OP_HALT, 1'b0, 0);
    chk("pc_en_pulses", pc_cnt, 2);
    chk("ir_en_pulses", ir_cnt, 2);

    do_reset();
    foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].az, tbl[i].nw);
    run_instr(OP_NOP, 1'b0, 0);
    chk("latency_count", lat_q.size(), NVEC);
    for (int i = 0; i < NVEC && i < lat_q.size(); i++)
      chk($sformatf("latency[%0d] op=%h", i, tbl[i].op), lat_q[i], tbl[i].lat + STEP_EXTRA);

    // Reset while a fetch request is waiting on memory
    bus.opcode = OP_LOAD;
    e = base(); e.mar_en = 1'b1;
    cyc(1'b1, e);
    e = base(); e.mem_req = 1'b1;
    cyc(1'b0, e);
    cyc(1'b0, e);
    rst = 1'b1;
    cyc(1'b1, '0);
    rst = 1'b0;
    ill = 1'b0;
    run_instr(OP_NOP, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
